mul_unit: RTL and testbench

//  Iterative multi-cycle integer multiplier for the MIPS `mul` instruction (funct 6'b011000).
//  The ALU control decoder flags `mul` with cross_control; this unit receives that request and computes rd = low WIDTH bits of rs*rt.
//  It stalls the pipeline while busy and returns the result with a one-cycle done pulse for writeback.

---
 rtl/mips_pkg.sv | 13 +
 rtl/mul_step.sv | 21 ++
 rtl/mul_unit.sv | 112 +++++++++++
 tb/tb_mul_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and multiplier state encodings.
package mips_pkg;

   localparam logic [5:0] FUNCT_MUL  = 6'b011000;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// One multiply iteration: adds the partial products of STEP multiplier bits to the accumulator.
module mul_step #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 1
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [STEP-1:0]  b_i,
   output logic [WIDTH-1:0] sum_o
);

   always_comb begin
      sum_o = acc_i;
      for (int i = 0; i < STEP; i++) begin
         if (b_i[i]) begin
            sum_o = sum_o + (a_i << i);
         end
      end
   end

endmodule

// File: rtl/mul_unit.sv
// Iterative multiplier for MIPS mul: low WIDTH bits of src1*src2, STEP bits per cycle.
module mul_unit
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  flush_i,
   input  logic [WIDTH-1:0]      src1_i,
   input  logic [WIDTH-1:0]      src2_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   output logic                  busy_o,
   output logic                  stall_o,
   output logic                  done_o,
   output logic [WIDTH-1:0]      result_o,
   output logic [REG_ADDR_W-1:0] rd_o
);

   localparam int unsigned N    = WIDTH / STEP;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

   mul_state_e state_q, state_d;
   logic [WIDTH-1:0]      a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic [WIDTH-1:0]      result_q, result_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [REG_ADDR_W-1:0] tag_q, tag_d, rd_q, rd_d;
   logic [WIDTH-1:0]      step_sum;

   mul_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .acc_i (acc_q),
      .a_i   (a_q),
      .b_i   (b_q[STEP-1:0]),
      .sum_o (step_sum)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      tag_d    = tag_q;
      result_d = result_q;
      rd_d     = rd_q;
      unique case (state_q)
         S_IDLE: begin
            // Flush outranks a simultaneous start.
            if (start_i && !flush_i) begin
               a_d     = src1_i;
               b_d     = src2_i;
               tag_d   = rd_i;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d = step_sum;
               a_d   = a_q << STEP;
               b_d   = b_q >> STEP;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  result_d = step_sum;
                  rd_d     = tag_q;
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         tag_q    <= '0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         tag_q    <= tag_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

   assign busy_o   = (state_q == S_RUN);
   assign done_o   = (state_q == S_DONE);
   assign stall_o  = ((state_q == S_IDLE) && start_i) || (state_q == S_RUN);
   assign result_o = result_q;
   assign rd_o     = rd_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit with STEP=1 and STEP=4 instances.
module tb_mul_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start1 = 1'b0, start4 = 1'b0, flush = 1'b0;
   logic [31:0] src1 = '0, src2 = '0;
   logic [4:0]  rd = '0;

   logic        busy1, stall1, done1, busy4, stall4, done4;
   logic [31:0] res1, res4;
   logic [4:0]  rdo1, rdo4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mul_unit #(.WIDTH(32), .STEP(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .flush_i(flush),
      .src1_i(src1), .src2_i(src2), .rd_i(rd),
      .busy_o(busy1), .stall_o(stall1), .done_o(done1), .result_o(res1), .rd_o(rdo1)
   );

   mul_unit #(.WIDTH(32), .STEP(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4), .flush_i(flush),
      .src1_i(src1), .src2_i(src2), .rd_i(rd),
      .busy_o(busy4), .stall_o(stall4), .done_o(done4), .result_o(res4), .rd_o(rdo4)
   );

   // Drives one request for 60 cycles; operands change after cycle 0 to expose re-latching.
   task automatic run_mul(input bit w4, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int hold, input int flush_at,
                          output int done_k, output int stalls, output int dones,
                          output logic [31:0] res, output logic [4:0] rdo);
      done_k = -1; stalls = 0; dones = 0; res = '0; rdo = '0;
      @(negedge clk);
      for (int k = 0; k < 60; k++) begin
         if (k == 0) begin
            src1 = a; src2 = b; rd = tag;
         end else begin
            src1 = ~a; src2 = b + 32'd3; rd = ~tag;
         end
         if (w4) start4 = (k < hold);
         else    start1 = (k < hold);
         flush = (k == flush_at);
         #1;
         if (w4 ? stall4 : stall1) stalls++;
         if (w4 ? done4 : done1) begin
            dones++;
            if (done_k < 0) begin
               done_k = k;
               res    = w4 ? res4 : res1;
               rdo    = w4 ? rdo4 : rdo1;
            end
         end
         @(negedge clk);
      end
      start1 = 1'b0; start4 = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      total++;
      if ({busy1, done1, res1, rdo1, busy4, done4, res4, rdo4} !== '0) begin
         bad++; $display("FAIL reset_outputs: got %h/%h/%h/%h want 0", busy1, done1, res1, rdo1);
      end
      total++;
      if (stall1 !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall1); end
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if ({busy1, done1} !== 2'b00) begin
         bad++; $display("FAIL reset_release: busy/done %b%b want 00", busy1, done1);
      end
   endtask

   task automatic test_basic;
      int dk, st, dn; logic [31:0] r; logic [4:0] t;
      run_mul(1'b0, 32'd6, 32'd7, 5'd13, 1, -1, dk, st, dn, r, t);
      total++; if (r !== 32'd42) begin bad++; $display("FAIL basic_result: got %h want 0000002a", r); end
      total++; if (t !== 5'd13) begin bad++; $display("FAIL basic_rd: got %0d want 13", t); end
      total++; if (st !== 33) begin bad++; $display("FAIL basic_stall_cycles: got %0d want 33", st); end
      total++; if (dn !== 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", dn); end
      total++; if (dk !== 33) begin bad++; $display("FAIL basic_latency: got %0d want 33", dk); end
      total++;
      if (res1 !== 32'd42 || rdo1 !== 5'd13) begin
         bad++; $display("FAIL basic_hold: got %h/%0d want 0000002a/13", res1, rdo1);
      end
   endtask

   task automatic test_wrap;
      logic [31:0] av [3];
      logic [31:0] bv [3];
      logic [31:0] ev [3];
      int dk, st, dn; logic [31:0] r; logic [4:0] t;
      av[0] = 32'hFFFFFFFF; bv[0] = 32'hFFFFFFFF; ev[0] = 32'h00000001;
      av[1] = 32'hFFFFFFFD; bv[1] = 32'd5;        ev[1] = 32'hFFFFFFF1;
      av[2] = 32'h80000000; bv[2] = 32'd2;        ev[2] = 32'h00000000;
      for (int i = 0; i < 3; i++) begin
         run_mul(1'b0, av[i], bv[i], 5'(i + 20), 1, -1, dk, st, dn, r, t);
         total++;
         if (r !== ev[i] || dn !== 1) begin
            bad++; $display("FAIL wrap_%0d: got %h (%0d pulses) want %h (1 pulse)", i, r, dn, ev[i]);
         end
         total++;
         if (t !== 5'(i + 20)) begin bad++; $display("FAIL wrap_rd_%0d: got %0d want %0d", i, t, i + 20); end
      end
   endtask

   task automatic test_start_held;
      int dk, st, dn; logic [31:0] r; logic [4:0] t;
      run_mul(1'b0, 32'd1000, 32'd3, 5'd7, 33, -1, dk, st, dn, r, t);
      total++; if (dn !== 1) begin bad++; $display("FAIL held_pulses: got %0d want 1", dn); end
      total++; if (r !== 32'd3000) begin bad++; $display("FAIL held_result: got %h want 00000bb8", r); end
      total++; if (t !== 5'd7) begin bad++; $display("FAIL held_rd: got %0d want 7", t); end
      total++; if (dk !== 33) begin bad++; $display("FAIL held_latency: got %0d want 33", dk); end
   endtask

   task automatic test_flush;
      int dk, st, dn; logic [31:0] r; logic [4:0] t;
      run_mul(1'b0, 32'd123, 32'd456, 5'd9, 1, 10, dk, st, dn, r, t);
      total++; if (dn !== 0) begin bad++; $display("FAIL flush_pulses: got %0d want 0", dn); end
      total++; if (st !== 11) begin bad++; $display("FAIL flush_stall_cycles: got %0d want 11", st); end
      total++;
      if (res1 !== 32'd3000 || rdo1 !== 5'd7) begin
         bad++; $display("FAIL flush_hold: got %h/%0d want 00000bb8/7", res1, rdo1);
      end
      run_mul(1'b0, 32'd11, 32'd12, 5'd4, 1, -1, dk, st, dn, r, t);
      total++;
      if (r !== 32'd132 || dn !== 1 || dk !== 33) begin
         bad++; $display("FAIL flush_restart: got %h/%0d/%0d want 00000084/1/33", r, dn, dk);
      end
      // Flush together with start in IDLE drops the request.
      run_mul(1'b0, 32'd5, 32'd5, 5'd2, 1, 0, dk, st, dn, r, t);
      total++;
      if (dn !== 0 || st !== 1 || res1 !== 32'd132) begin
         bad++; $display("FAIL flush_idle_start: got pulses %0d stalls %0d res %h want 0/1/00000084",
                         dn, st, res1);
      end
   endtask

   task automatic test_reset_mid;
      int dn;
      @(negedge clk);
      src1 = 32'd77; src2 = 32'd88; rd = 5'd30; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before: got %b want 1", busy1); end
      rst = 1'b0;
      #1;
      total++;
      if ({busy1, done1, stall1, res1, rdo1} !== '0) begin
         bad++; $display("FAIL rst_mid_outputs: got %b%b%b %h %0d want all 0", busy1, done1, stall1,
                         res1, rdo1);
      end
      @(negedge clk);
      rst = 1'b1;
      dn = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (done1 || busy1) dn++;
         @(negedge clk);
      end
      total++; if (dn !== 0) begin bad++; $display("FAIL rst_mid_spurious: got %0d active cycles want 0", dn); end
   endtask

   task automatic test_step4;
      int dk, st, dn; logic [31:0] r; logic [4:0] t;
      run_mul(1'b1, 32'h12345678, 32'h9ABCDEF0, 5'd17, 1, -1, dk, st, dn, r, t);
      total++; if (r !== 32'h242D2080) begin bad++; $display("FAIL step4_result: got %h want 242d2080", r); end
      total++; if (dk !== 9) begin bad++; $display("FAIL step4_latency: got %0d want 9", dk); end
      total++; if (st !== 9 || dn !== 1) begin
         bad++; $display("FAIL step4_stall_pulses: got %0d/%0d want 9/1", st, dn);
      end
      total++; if (t !== 5'd17) begin bad++; $display("FAIL step4_rd: got %0d want 17", t); end
   endtask

   task automatic test_back_to_back;
      int dk, st, dn; logic [31:0] r; logic [4:0] t;
      run_mul(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1, -1, dk, st, dn, r, t);
      total++; if (r !== 32'h1) begin bad++; $display("FAIL b2b_first: got %h want 00000001", r); end
      run_mul(1'b1, 32'hFFFFFFFD, 32'd5, 5'd2, 1, -1, dk, st, dn, r, t);
      total++;
      if (r !== 32'hFFFFFFF1 || t !== 5'd2) begin
         bad++; $display("FAIL b2b_second: got %h/%0d want fffffff1/2", r, t);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_start_held();
      test_flush();
      test_step4();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
